mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage pipeline. It registers and holds one memory transaction at a time, returns data and one-cycle ready pulses to each requester, and drives a pipeline-wide stall. The stall is combined with the load-use stall from the control unit. A watchdog converts a missing memory acknowledge into a sticky bus error.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles a granted access may wait for mem_ack (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  AW  fetch address (pc)
if_rdata  out  DW  fetched instruction, valid while if_ready=1
if_ready  out  1  one-cycle fetch completion pulse
dm_re  in  1  load request (MEM-stage m2reg), held until dm_ready
dm_we  in  1  store request (MEM-stage wmem), held until dm_ready
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data, valid while dm_ready=1
dm_ready  out  1  one-cycle data completion pulse
mem_req  out  1  memory transaction strobe
mem_we  out  1  1 = write
mem_addr  out  AW  transaction address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid with mem_ack
mem_ack  in  1  transaction complete
stall  out  1  freeze PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB
bus_err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, D_ACC, I_ACC, ERR.
- Reset (async): state IDLE; every output 0; dm_rdata/if_rdata 0; watchdog 0. Reset during an access drops mem_req immediately. The access is discarded.
- Eligibility in IDLE:
  - The data requester is eligible when (dm_re|dm_we) & ~dm_ready.
  - The fetch requester is eligible when if_req & ~if_ready.
  - A requester whose ready pulse is high this cycle is not eligible, so a held request is never serviced twice.
- Grant priority: data over fetch (the older instruction wins).
- On grant at edge T:
  - mem_req=1 from T, with mem_addr/mem_we/mem_wdata latched from the winner.
  - For a fetch grant, mem_we=0 and mem_wdata is held.
  - dm_we & dm_re together is treated as a write.
  - Next state is D_ACC or I_ACC.
  - The latched transaction fields stay stable until ack, whatever the inputs do.
- In D_ACC/I_ACC, mem_ack sampled 1 at an edge causes the following:
  - mem_req=0 and state -> IDLE.
  - The matching ready is 1 for exactly one cycle.
  - For reads, the matching rdata is registered from mem_rdata.
  - For stores, dm_rdata keeps its previous value.
- Watchdog: cleared on grant and incremented each cycle in D_ACC/I_ACC without ack.
  - When it reaches TIMEOUT-1 with no ack, the next edge goes to ERR: mem_req=0 and bus_err=1.
  - mem_ack in that same cycle wins, giving normal completion with no error.
- ERR is absorbing until reset: bus_err=1, stall=1, no grants, and mem_ack is ignored.
- IDLE throughput: from the cycle after a ready pulse a new grant is possible. Minimum access is 1 grant cycle + ack latency + 1 ready cycle.
- mem_ack outside D_ACC/I_ACC is ignored.
- stall (combinational) = ((dm_re|dm_we) & ~dm_ready) | (if_req & ~if_ready) | bus_err.
  - The pipeline advances on the edge ending a ready cycle only when no other request is pending.
- Latency: request rising before edge T0, with mem_ack high in cycle T0+k (k>=1), gives ready high in cycle T0+k+1.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0040, mem_ack after 2 cycles with mem_rdata=0x2001_0005 -> mem_req 2 cycles, mem_we=0, if_ready one cycle, if_rdata=0x2001_0005, stall low exactly in the ready cycle.
- Conflict: if_req and dm_re (addr 0x100) rise together, each acked after 1 cycle -> memory sees 0x100 first, then the fetch address. dm_ready precedes if_ready, and stall stays high until if_ready.
- Store: dm_we=1, dm_addr=0x200, dm_wdata=0xDEAD_BEEF -> mem_we=1 and mem_wdata=0xDEAD_BEEF held through ack. dm_rdata keeps its prior value, and dm_ready pulses once.
- Held request: dm_re held high one extra cycle after dm_ready -> no second grant in the ready cycle. A regrant occurs only if dm_re is still high the cycle after.
- Timeout: TIMEOUT=16, no mem_ack -> mem_req drops after 16 cycles, bus_err=1 and stall=1 persist. A later mem_ack changes nothing.
- Timeout tie and reset: mem_ack exactly on cycle 16 -> normal completion, bus_err=0. Asserting reset mid-access -> mem_req, ready, stall and bus_err go 0 immediately, and a fresh fetch after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency unified memory between the
// instruction-fetch requester (IF stage) and the data requester (MEM stage
// lw/sw). One transaction is registered and held at a time. Data requests
// win over fetch requests because they belong to the older instruction.
// A watchdog turns a missing mem_ack into a sticky bus error.
//
// Handshake: a requester raises its request (if_req, or dm_re/dm_we) and
// holds it and its address/data stable until it sees its ready pulse. Ready
// is high for exactly one cycle. Read data is valid while ready is high.
// While its ready is high, a requester cannot be granted again, so a request
// held through the ready cycle is not serviced twice. The memory side sees
// mem_req held high, with stable mem_addr/mem_we/mem_wdata, until the cycle
// in which it returns mem_ack (and mem_rdata for reads).
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   if_req, if_addr       fetch request and address (pc)
//   if_rdata, if_ready    fetched instruction and one-cycle completion pulse
//   dm_re, dm_we          load / store request (both high is a store)
//   dm_addr, dm_wdata     data address and store data
//   dm_rdata, dm_ready    load data and one-cycle completion pulse
//   mem_req, mem_we       memory strobe and write enable
//   mem_addr, mem_wdata   latched transaction address and write data
//   mem_rdata, mem_ack    memory read data and completion
//   stall                 pipeline-wide freeze (pending request or bus error)
//   bus_err               sticky watchdog timeout flag
//   fsm_state             current arbiter state, for debug and checkers
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_re,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          bus_err,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        ERR   = 2'd3
    } state_t;

    // The watchdog counts 0 .. TIMEOUT-1 and never wraps: reaching the last
    // value without an ack leaves the access state.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [WD_W-1:0] watchdog;

    logic dm_eligible;
    logic if_eligible;
    logic in_access;
    logic grant_dm;
    logic grant_if;

    // A requester whose ready pulse is high this cycle has just been served
    // and must not be granted again on the same held request.
    assign dm_eligible = (dm_re | dm_we) & ~dm_ready;
    assign if_eligible = if_req & ~if_ready;

    assign in_access = (state == D_ACC) || (state == I_ACC);
    assign grant_dm  = (state == IDLE) && dm_eligible;
    assign grant_if  = (state == IDLE) && !dm_eligible && if_eligible;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dm_eligible) begin
                    state_next = D_ACC;
                end else if (if_eligible) begin
                    state_next = I_ACC;
                end
            end
            D_ACC, I_ACC: begin
                // An ack in the watchdog's last cycle still completes normally.
                if (mem_ack) begin
                    state_next = IDLE;
                end else if (watchdog == WD_LAST) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State-decoded outputs. mem_req follows the state register directly so
    // an asynchronous reset removes it at once.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req   = in_access;
        bus_err   = (state == ERR);
        fsm_state = state;
        stall     = ~reset & (dm_eligible | if_eligible | (state == ERR));
    end

    // -----------------------------------------------------------------------
    // Transaction latch, watchdog, completion pulses and read data
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            watchdog  <= '0;
            dm_ready  <= 1'b0;
            if_ready  <= 1'b0;
            dm_rdata  <= '0;
            if_rdata  <= '0;
        end else begin
            dm_ready <= (state == D_ACC) && mem_ack;
            if_ready <= (state == I_ACC) && mem_ack;

            if (grant_dm) begin
                // A simultaneous load and store request is handled as a store.
                mem_addr  <= dm_addr;
                mem_we    <= dm_we;
                mem_wdata <= dm_wdata;
                watchdog  <= '0;
            end else if (grant_if) begin
                // Fetches leave the previous write data in place.
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
                watchdog <= '0;
            end else if (in_access && !mem_ack && (watchdog != WD_LAST)) begin
                watchdog <= watchdog + WD_W'(1);
            end

            // Stores complete without touching the last load result.
            if ((state == D_ACC) && mem_ack && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
            if ((state == I_ACC) && mem_ack) begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int TIMEOUT   = 16;
    localparam int LAT_NEVER = 255;

    // ---------------------------------------------------------------- clock/reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_re;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          bus_err;
    logic [1:0]    fsm_state;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_re     (dm_re),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_err   (bus_err),
        .fsm_state (fsm_state)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Memory contents plus a transaction-level view of the arbiter: which
    // requester owns the memory, what it asked for, and what each requester
    // must see when its ready pulse arrives.
    logic [DW-1:0] mem_model [bit [31:0]];
    logic [DW-1:0] dm_exp_q[$];
    logic [DW-1:0] if_exp_q[$];
    logic [AW-1:0] txn_q[$];

    logic          m_busy, m_owner_d, m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] dm_last;
    int            m_cnt, m_lat;
    logic          rdy_d_exp, rdy_i_exp;

    int   lat_mode;   // 0: random 1..4, LAT_NEVER: no ack, else fixed latency
    logic spur_en;    // random acks while no access is outstanding
    logic force_ack;  // ack every cycle while no access is outstanding

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner_d = 0; m_err = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_cnt = 0; m_lat = 1;
        rdy_d_exp = 0; rdy_i_exp = 0; dm_last = '0;
        dm_exp_q.delete(); if_exp_q.delete();
    endtask

    task automatic monitor_cycle();
        logic          ack;
        logic [DW-1:0] rd;
        logic          dm_pend, if_pend, new_d, new_i;
        dm_pend = (dm_re | dm_we) & ~rdy_d_exp;
        if_pend = if_req & ~rdy_i_exp;

        check_eq("mem_req", mem_req, m_busy);
        check_eq("dm_ready", dm_ready, rdy_d_exp);
        check_eq("if_ready", if_ready, rdy_i_exp);
        check_eq("bus_err", bus_err, m_err);
        check_eq("stall", stall, dm_pend | if_pend | m_err);
        if (m_busy) begin
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_we", mem_we, m_we);
            if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        end
        if (rdy_d_exp && dm_exp_q.size() > 0) check_eq("dm_rdata", dm_rdata, dm_exp_q.pop_front());
        if (rdy_i_exp && if_exp_q.size() > 0) check_eq("if_rdata", if_rdata, if_exp_q.pop_front());

        // Memory responder for this cycle.
        ack = 0;
        rd  = $urandom;
        if (m_busy) begin
            m_cnt++;
            ack = (m_lat != LAT_NEVER) && (m_cnt == m_lat);
            if (ack && !m_we) rd = mem_read(m_addr);
        end else if (force_ack || (spur_en && ($urandom_range(0, 3) == 0))) begin
            ack = 1;
        end
        mem_ack   = ack;
        mem_rdata = rd;

        // What the coming edge must do.
        new_d = 0;
        new_i = 0;
        if (m_busy && ack) begin
            if (m_owner_d) begin
                new_d = 1;
                if (m_we) begin
                    mem_model[m_addr] = m_wdata;
                    dm_exp_q.push_back(dm_last);
                end else begin
                    dm_last = rd;
                    dm_exp_q.push_back(rd);
                end
            end else begin
                new_i = 1;
                if_exp_q.push_back(rd);
            end
            txn_q.push_back(m_addr);
            m_busy = 0;
        end else if (m_busy && (m_cnt == TIMEOUT)) begin
            m_busy = 0;
            m_err  = 1;
        end else if (!m_busy && !m_err && (dm_pend || if_pend)) begin
            m_busy    = 1;
            m_cnt     = 0;
            m_owner_d = dm_pend;
            if (dm_pend) begin
                m_addr  = dm_addr;
                m_we    = dm_we;
                m_wdata = dm_wdata;
            end else begin
                m_addr = if_addr;
                m_we   = 0;
            end
            m_lat = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
        end
        rdy_d_exp = new_d;
        rdy_i_exp = new_i;
    endtask

    initial begin : monitor
        mem_ack   = 0;
        mem_rdata = '0;
        model_reset();
        forever begin
            @(negedge clock);
            if (reset) begin
                model_reset();
                mem_ack = 0;
            end else begin
                monitor_cycle();
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    int   d_at, i_at, d_cnt, i_cnt;
    logic stall_ok, run_done;

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Waits for every currently raised request to complete, dropping each
    // one right after its ready cycle, then watches a short tail.
    task automatic run_requests(input string tag, input int budget);
        logic want_d, want_i;
        want_d = dm_re | dm_we;
        want_i = if_req;
        d_at = -1; i_at = -1; d_cnt = 0; i_cnt = 0;
        stall_ok = 1; run_done = 0;
        for (int c = 0; c < budget && !run_done; c++) begin
            @(negedge clock);
            if (dm_ready) begin d_cnt++; if (d_at < 0) d_at = c; end
            if (if_ready) begin i_cnt++; if (i_at < 0) i_at = c; end
            if (want_i && i_at < 0 && !stall) stall_ok = 0;
            if ((!want_d || d_at >= 0) && (!want_i || i_at >= 0)) run_done = 1;
            @(posedge clock);
            #1;
            if (d_at == c) begin dm_re = 0; dm_we = 0; end
            if (i_at == c) if_req = 0;
        end
        check_eq({tag, "_done"}, run_done, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (dm_ready) d_cnt++;
            if (if_ready) i_cnt++;
        end
        #1;
    endtask

    task automatic pulse_reset_check(input string tag);
        @(posedge clock);
        #2;
        reset = 1;
        #1;
        check_eq({tag, "_mem_req"}, mem_req, 0);
        check_eq({tag, "_if_ready"}, if_ready, 0);
        check_eq({tag, "_dm_ready"}, dm_ready, 0);
        check_eq({tag, "_stall"}, stall, 0);
        check_eq({tag, "_bus_err"}, bus_err, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic dm_driver(input int n);
        int   op;
        logic got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            @(posedge clock);
            #1;
            op       = $urandom_range(0, 2);
            dm_addr  = 32'($urandom_range(0, 15)) << 2;
            dm_wdata = $urandom;
            dm_re    = (op != 1);
            dm_we    = (op != 0);
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clock);
                if (dm_ready) got = 1;
            end
            check_eq("dm_rand_done", got, 1);
            @(posedge clock);
            #1;
            dm_re = 0;
            dm_we = 0;
        end
    endtask

    task automatic if_driver(input int n);
        logic got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            @(posedge clock);
            #1;
            if_addr = 32'($urandom_range(0, 15)) << 2;
            if_req  = 1;
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clock);
                if (if_ready) got = 1;
            end
            check_eq("if_rand_done", got, 1);
            @(posedge clock);
            #1;
            if_req = 0;
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin : main
        int   req_cyc;
        logic got;

        reset = 1; if_req = 0; if_addr = '0; dm_re = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0;
        lat_mode = 1; spur_en = 0; force_ack = 0;

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_if_ready", if_ready, 0);
        check_eq("rst_dm_ready", dm_ready, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_dm_rdata", dm_rdata, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_stall", stall, 0);
        reset = 0;
        idle(2);

        // Fetch only, ack in the second access cycle.
        mem_model[32'h40] = 32'h2001_0005;
        lat_mode = 2;
        if_addr = 32'h40;
        if_req  = 1;
        req_cyc = 0;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clock);
            if (mem_req) req_cyc++;
            if (if_ready) begin
                got = 1;
                check_eq("t1_if_rdata", if_rdata, 32'h2001_0005);
                check_eq("t1_stall_in_ready", stall, 0);
            end
        end
        check_eq("t1_got_ready", got, 1);
        check_eq("t1_req_cycles", req_cyc, 2);
        @(posedge clock);
        #1;
        if_req = 0;
        idle(3);

        // Fetch and load rise together: the load goes first.
        lat_mode = 1;
        txn_q.delete();
        if_addr = 32'h44; if_req = 1;
        dm_addr = 32'h100; dm_re = 1;
        run_requests("t2", 40);
        check_eq("t2_txn_count", txn_q.size(), 2);
        if (txn_q.size() >= 2) begin
            check_eq("t2_first_addr", txn_q[0], 32'h100);
            check_eq("t2_second_addr", txn_q[1], 32'h44);
        end
        check_eq("t2_dm_before_if", (d_at >= 0) && (d_at < i_at), 1);
        check_eq("t2_stall_until_if_ready", stall_ok, 1);
        idle(2);

        // Store: write data held through ack, load data unchanged.
        lat_mode = 3;
        dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_we = 1;
        run_requests("t3", 40);
        check_eq("t3_dm_rdata_kept", dm_rdata, mem_read(32'h100));
        check_eq("t3_ready_pulses", d_cnt, 1);
        idle(2);

        // Held load: no regrant in the ready cycle, regrant one cycle later.
        lat_mode = 1;
        dm_addr = 32'h200; dm_re = 1;
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clock);
            if (dm_ready) got = 1;
        end
        check_eq("t4_first_ready", got, 1);
        check_eq("t4_readback", dm_rdata, 32'hDEAD_BEEF);
        @(negedge clock);
        check_eq("t4_no_grant_in_ready", mem_req, 0);
        check_eq("t4_ready_single", dm_ready, 0);
        @(posedge clock);
        #1;
        dm_re = 0;
        @(negedge clock);
        check_eq("t4_regrant", mem_req, 1);
        got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clock);
            if (dm_ready) got = 1;
        end
        check_eq("t4_second_ready", got, 1);
        idle(2);

        // Timeout: no ack ever.
        lat_mode = LAT_NEVER;
        if_addr = 32'h80; if_req = 1;
        req_cyc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (mem_req) req_cyc++;
        end
        check_eq("t5_req_cycles", req_cyc, TIMEOUT);
        check_eq("t5_bus_err", bus_err, 1);
        check_eq("t5_stall", stall, 1);
        force_ack = 1;
        repeat (3) @(negedge clock);
        check_eq("t5_ack_ignored_err", bus_err, 1);
        check_eq("t5_ack_ignored_req", mem_req, 0);
        check_eq("t5_ack_ignored_rdy", if_ready, 0);
        @(posedge clock);
        #1;
        force_ack = 0;
        if_req = 0;
        @(negedge clock);
        check_eq("t5_stall_sticky", stall, 1);
        if_req = 1;
        pulse_reset_check("t5_rst");
        if_req = 0;
        idle(2);

        // Ack in the last watchdog cycle completes normally.
        lat_mode = TIMEOUT;
        if_addr = 32'h84; if_req = 1;
        run_requests("t6", 40);
        check_eq("t6_no_err", bus_err, 0);
        check_eq("t6_rdata", if_rdata, mem_read(32'h84));
        idle(2);

        // Reset in the middle of an access, then a fresh fetch.
        lat_mode = LAT_NEVER;
        if_addr = 32'h88; if_req = 1;
        repeat (3) @(negedge clock);
        check_eq("t7_in_access", mem_req, 1);
        pulse_reset_check("t7_rst");
        lat_mode = 2;
        run_requests("t7_after", 40);
        check_eq("t7_rdata", if_rdata, mem_read(32'h88));
        check_eq("t7_no_err", bus_err, 0);
        idle(2);

        // Random traffic from both requesters with stray acks.
        lat_mode = 0;
        spur_en  = 1;
        fork
            dm_driver(40);
            if_driver(40);
        join
        spur_en = 0;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
